// File: rtl/dbus_pkg.sv
// ----------------------------------------------------------------------------
// dbus_pkg
//   Shared definitions for the data-bus bridge between the CPU data-access
//   port and the data RAM / MMIO fabric.
//   - state_e                : bridge FSM encoding (IDLE / REQ / RESP)
//   - DEFAULT_ERR_RDATA      : read data returned when a request times out
//   - DEFAULT_TIMEOUT_CYCLES : REQ cycles without ready before a forced error
// ----------------------------------------------------------------------------
package dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hDEAD_BEEF;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dbus_timeout.sv
// ----------------------------------------------------------------------------
// dbus_timeout
//   Wait-cycle counter for the bridge's REQ state. Only instantiated when the
//   bridge is built with DBUS_TIMEOUT_EN.
//
//   Ports:
//     cpu_clk   in  clock
//     cpu_rstn  in  asynchronous active-low reset
//     clear_i   in  hold the count at zero (asserted whenever not in REQ)
//     enable_i  in  count one wait cycle (REQ without ready)
//     tc_o      out terminal-count pulse: this enabled cycle is the
//                   TIMEOUT_CYCLES-th wait cycle
// ----------------------------------------------------------------------------
module dbus_timeout
    import dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    // At least 8 bits, wider if the timeout value needs it.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of earlier wait cycles, so the cycle where it
    // equals TIMEOUT_CYCLES-1 is the last one allowed.
    assign tc_o = enable_i && (cnt_q == TC_VALUE);

endmodule

// File: rtl/dbus_bridge.sv
// ----------------------------------------------------------------------------
// dbus_bridge
//   Converts single-cycle read/write requests from the CPU data-access port
//   into a held req/ready handshake toward the data RAM / MMIO fabric. One
//   transaction outstanding at a time; one response pulse per request.
//
//   Build option: define DBUS_TIMEOUT_EN to add a REQ-state timeout that
//   forces an error response (bus_err pulse, ERR_RDATA for reads). Without
//   it REQ waits indefinitely and bus_err stays 0.
//
//   Ports:
//     cpu_clk, cpu_rstn   clock, asynchronous active-low reset
//     daccess_ren   in  4  read request (any nonzero value)
//     daccess_addr  in  32 byte address
//     daccess_wen   in  4  write byte strobes (nonzero = write)
//     daccess_wdata in  32 lane-aligned write data
//     daccess_valid out 1  read-data-valid pulse
//     daccess_rdata out 32 read word, held until the next read response
//     daccess_wresp out 1  write-complete pulse
//     mem_req       out 1  fabric request, held until mem_ready
//     mem_we        out 1  1 = write, 0 = read
//     mem_addr      out 32 word address ([1:0] = 0)
//     mem_wstrb     out 4  byte strobes (0 for reads)
//     mem_wdata     out 32 write data
//     mem_ready     in  1  fabric completion (sampled only in REQ)
//     mem_rdata     in  32 read data, valid with mem_ready
//     bus_err       out 1  timeout pulse, concurrent with the response
// ----------------------------------------------------------------------------
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic [3:0]  daccess_ren,
    input  logic [31:0] daccess_addr,
    input  logic [3:0]  daccess_wen,
    input  logic [31:0] daccess_wdata,
    output logic        daccess_valid,
    output logic [31:0] daccess_rdata,
    output logic        daccess_wresp,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:2] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timeout;

    // The byte offset never reaches the fabric; the core does lane handling.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^daccess_addr[1:0];

`ifdef DBUS_TIMEOUT_EN
    dbus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .clear_i  (state_q != ST_REQ),
        .enable_i ((state_q == ST_REQ) && !mem_ready),
        .tc_o     (timeout)
    );
`else
    assign timeout = 1'b0;

    // The timeout value only matters when the counter is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the
        // case below leaves a signal unassigned (which would infer a latch).
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                // A write wins over a simultaneous read; the read is dropped.
                if (|daccess_wen) begin
                    we_d    = 1'b1;
                    addr_d  = daccess_addr[31:2];
                    wstrb_d = daccess_wen;
                    wdata_d = daccess_wdata;
                    state_d = ST_REQ;
                end else if (|daccess_ren) begin
                    we_d    = 1'b0;
                    addr_d  = daccess_addr[31:2];
                    wstrb_d = 4'b0000;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ready has priority over a coincident terminal count.
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else if (timeout) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = ERR_RDATA;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Requests here violate the requester contract and are ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // All outputs come from registers or state decode; reset clears the state
    // asynchronously, so mem_req drops the moment cpu_rstn falls.
    assign mem_req       = (state_q == ST_REQ);
    assign mem_we        = we_q;
    assign mem_addr      = {addr_q, 2'b00};
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;
    assign daccess_rdata = rdata_q;
    assign daccess_valid = (state_q == ST_RESP) && !we_q;
    assign daccess_wresp = (state_q == ST_RESP) && we_q;
    assign bus_err       = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// ----------------------------------------------------------------------------
// tb_dbus_bridge
//   Directed bench for dbus_bridge. Inputs change and outputs are sampled 1ns
//   after each rising edge. Response pulses are also tallied on falling edges
//   so totals per scenario can be compared against hand-counted values.
//   Build with DBUS_TIMEOUT_EN to include the timeout scenarios
//   (TIMEOUT_CYCLES = 4).
// ----------------------------------------------------------------------------
module tb_dbus_bridge;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic [3:0]  daccess_ren;
    logic [31:0] daccess_addr;
    logic [3:0]  daccess_wen;
    logic [31:0] daccess_wdata;
    logic        daccess_valid;
    logic [31:0] daccess_rdata;
    logic        daccess_wresp;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    int n_valid = 0;
    int n_wresp = 0;
    int n_err   = 0;
    int n_req   = 0;

    dbus_bridge #(
        .TIMEOUT_CYCLES (4),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rstn      (cpu_rstn),
        .daccess_ren   (daccess_ren),
        .daccess_addr  (daccess_addr),
        .daccess_wen   (daccess_wen),
        .daccess_wdata (daccess_wdata),
        .daccess_valid (daccess_valid),
        .daccess_rdata (daccess_rdata),
        .daccess_wresp (daccess_wresp),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .bus_err       (bus_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    always @(negedge cpu_clk) begin
        if (daccess_valid === 1'b1) n_valid++;
        if (daccess_wresp === 1'b1) n_wresp++;
        if (bus_err === 1'b1)       n_err++;
        if (mem_req === 1'b1)       n_req++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_wresp = 0;
        n_err   = 0;
        n_req   = 0;
    endtask

    initial begin
        cpu_rstn      = 1'b0;
        daccess_ren   = 4'h0;
        daccess_addr  = 32'h0;
        daccess_wen   = 4'h0;
        daccess_wdata = 32'h0;
        mem_ready     = 1'b0;
        mem_rdata     = 32'h0;

        // ---------------- reset state ----------------
        #12;
        check("rst_mem_req",   {31'd0, mem_req},       32'd0);
        check("rst_mem_we",    {31'd0, mem_we},        32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb},     32'd0);
        check("rst_mem_addr",  mem_addr,               32'd0);
        check("rst_mem_wdata", mem_wdata,              32'd0);
        check("rst_rdata",     daccess_rdata,          32'd0);
        check("rst_valid",     {31'd0, daccess_valid}, 32'd0);
        check("rst_wresp",     {31'd0, daccess_wresp}, 32'd0);
        check("rst_bus_err",   {31'd0, bus_err},       32'd0);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        step();

        // ---------------- read, fast ready ----------------
        clear_counts();
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_1C02;
        step();                                   // E0: request sampled
        daccess_ren  = 4'h0;
        daccess_addr = 32'h0;
        check("rd_mem_req",   {31'd0, mem_req},   32'd1);
        check("rd_mem_we",    {31'd0, mem_we},    32'd0);
        check("rd_mem_addr",  mem_addr,           32'h0000_1C00);
        check("rd_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rd_valid_early", {31'd0, daccess_valid}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();                                   // E1: ready sampled
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("rd_valid",     {31'd0, daccess_valid}, 32'd1);
        check("rd_rdata",     daccess_rdata,          32'h1234_5678);
        check("rd_req_drop",  {31'd0, mem_req},       32'd0);
        check("rd_no_wresp",  {31'd0, daccess_wresp}, 32'd0);
        step();
        check("rd_valid_end", {31'd0, daccess_valid}, 32'd0);
        check("rd_rdata_hold", daccess_rdata,         32'h1234_5678);
        check("rd_n_valid",   n_valid, 32'd1);

        // ---------------- write, 3 wait cycles ----------------
        clear_counts();
        daccess_wen   = 4'b0011;
        daccess_addr  = 32'h0000_0041;
        daccess_wdata = 32'h0000_ABCD;
        step();
        daccess_wen   = 4'h0;
        daccess_addr  = 32'h0;
        daccess_wdata = 32'h0;
        check("wr_mem_we",    {31'd0, mem_we},    32'd1);
        check("wr_mem_addr",  mem_addr,           32'h0000_0040);
        check("wr_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
        check("wr_mem_wdata", mem_wdata,          32'h0000_ABCD);
        step();
        step();
        step();                                   // fourth REQ cycle
        check("wr_req_held",  {31'd0, mem_req},   32'd1);
        check("wr_strb_held", {28'd0, mem_wstrb}, 32'h3);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("wr_wresp",     {31'd0, daccess_wresp}, 32'd1);
        check("wr_no_valid",  {31'd0, daccess_valid}, 32'd0);
        step();
        check("wr_n_req",     n_req,   32'd4);
        check("wr_n_wresp",   n_wresp, 32'd1);
        check("wr_n_valid",   n_valid, 32'd0);
        check("wr_rdata_kept", daccess_rdata, 32'h1234_5678);

        // ---------------- simultaneous ren and wen ----------------
        clear_counts();
        daccess_ren   = 4'hF;
        daccess_wen   = 4'b1100;
        daccess_addr  = 32'h0000_0080;
        daccess_wdata = 32'h5A5A_0000;
        step();
        daccess_ren   = 4'h0;
        daccess_wen   = 4'h0;
        check("both_we",    {31'd0, mem_we},    32'd1);
        check("both_wstrb", {28'd0, mem_wstrb}, 32'hC);
        check("both_wdata", mem_wdata,          32'h5A5A_0000);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("both_wresp", {31'd0, daccess_wresp}, 32'd1);
        step();
        step();
        check("both_n_wresp", n_wresp, 32'd1);
        check("both_n_valid", n_valid, 32'd0);
        check("both_n_req",   n_req,   32'd1);
        check("both_rdata",   daccess_rdata, 32'h1234_5678);

        // ---------------- back-to-back read then write ----------------
        clear_counts();
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0104;
        step();
        daccess_ren  = 4'h0;
        mem_ready    = 1'b1;
        mem_rdata    = 32'hCAFE_F00D;
        step();
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;
        check("b2b_valid", {31'd0, daccess_valid}, 32'd1);
        check("b2b_rdata", daccess_rdata,          32'hCAFE_F00D);
        step();                                   // IDLE: next request here
        daccess_wen   = 4'b1111;
        daccess_addr  = 32'h0000_0108;
        daccess_wdata = 32'h0BAD_C0DE;
        step();
        daccess_wen   = 4'h0;
        check("b2b_wr_req",  {31'd0, mem_req}, 32'd1);
        check("b2b_wr_we",   {31'd0, mem_we},  32'd1);
        check("b2b_wr_addr", mem_addr,         32'h0000_0108);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("b2b_wresp", {31'd0, daccess_wresp}, 32'd1);
        step();
        check("b2b_n_valid", n_valid, 32'd1);
        check("b2b_n_wresp", n_wresp, 32'd1);

        // ---------------- reset mid-REQ ----------------
        clear_counts();
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0200;
        step();
        daccess_ren  = 4'h0;
        check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        cpu_rstn = 1'b0;
        #1;
        check("rst_mid_req_drop",  {31'd0, mem_req}, 32'd0);
        check("rst_mid_addr",      mem_addr,          32'd0);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        step();
        check("rst_mid_idle",      {31'd0, mem_req}, 32'd0);
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0304;
        step();
        daccess_ren  = 4'h0;
        check("post_rst_req",  {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h7654_3210;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("post_rst_valid", {31'd0, daccess_valid}, 32'd1);
        check("post_rst_rdata", daccess_rdata,          32'h7654_3210);
        step();
        check("post_rst_n_valid", n_valid, 32'd1);

`ifdef DBUS_TIMEOUT_EN
        // ---------------- timeout, read with no ready ----------------
        clear_counts();
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0400;
        step();
        daccess_ren  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("to_req_held", {31'd0, mem_req}, 32'd1);
            step();
        end
        check("to_valid",   {31'd0, daccess_valid}, 32'd1);
        check("to_bus_err", {31'd0, bus_err},       32'd1);
        check("to_rdata",   daccess_rdata,          32'hDEAD_BEEF);
        step();
        check("to_err_end", {31'd0, bus_err}, 32'd0);
        check("to_n_err",   n_err, 32'd1);

        // ---------------- ready coinciding with terminal count ----------------
        clear_counts();
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0500;
        step();
        daccess_ren  = 4'h0;
        step();
        step();
        step();                                   // fourth REQ cycle
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA_55AA;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("tc_valid",   {31'd0, daccess_valid}, 32'd1);
        check("tc_no_err",  {31'd0, bus_err},       32'd0);
        check("tc_rdata",   daccess_rdata,          32'h55AA_55AA);
        step();
        check("tc_n_err",   n_err, 32'd0);
`else
        // ---------------- no timeout: REQ waits indefinitely ----------------
        clear_counts();
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0400;
        step();
        daccess_ren  = 4'h0;
        repeat (300) step();
        check("nto_req_held", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h0F0F_0F0F;
        step();
        mem_ready = 1'b0;
        check("nto_valid", {31'd0, daccess_valid}, 32'd1);
        check("nto_rdata", daccess_rdata,          32'h0F0F_0F0F);
        step();
        check("nto_n_err",   n_err,   32'd0);
        check("nto_n_valid", n_valid, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
